// File: rtl/mem_access_unit.sv
// Load/store initiator: byte address to word index, RMW for sub-word stores, extended sub-word loads.
// Latency accept->DONE: fault 1, SW 2, load 3, SB/SH 4 cycles; READY low while busy, one request in flight.
module mem_access_unit #(
    parameter int DEPTH = 32
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic [3:0]  OP,
    input  logic [31:0] BYTE_ADDR,
    input  logic [31:0] STORE_DATA,
    output logic        READY,
    output logic        DONE,
    output logic        FAULT,
    output logic [31:0] LOAD_DATA,
    output logic        MEMREAD,
    output logic        MEMWRITE,
    output logic [31:0] ADDR,
    output logic [31:0] WRITE_DATA,
    input  logic [31:0] READ_DATA
);

    typedef enum logic [1:0] {IDLE, RD, CAP, WR} state_t;

    state_t      state, state_n;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        legal, misaligned, range_err, req_fault, accept;
    logic [15:0] rd_lane;
    logic [31:0] ld_ext;
    logic [31:0] merged;

    always_comb begin
        case (OP)
            4'b0000, 4'b0001, 4'b0010, 4'b0100,
            4'b0101, 4'b1000, 4'b1001, 4'b1010: legal = 1'b1;
            default:                            legal = 1'b0;
        endcase
        misaligned = (OP[1:0] == 2'b01 && BYTE_ADDR[0]) ||
                     (OP[1:0] == 2'b10 && BYTE_ADDR[1:0] != 2'b00);
        range_err  = BYTE_ADDR[31:2] >= 30'(DEPTH);
        req_fault  = !legal || misaligned || range_err;
        accept     = REQ && (state == IDLE);
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n    = state;
        READY      = 1'b0;
        MEMREAD    = 1'b0;
        MEMWRITE   = 1'b0;
        ADDR       = 32'd0;
        WRITE_DATA = 32'd0;
        case (state)
            IDLE: begin
                READY = 1'b1;
                if (accept && !req_fault)
                    state_n = (OP == 4'b1010) ? WR : RD;
            end
            RD: begin
                MEMREAD = 1'b1;
                ADDR    = {2'b00, addr_q[31:2]};
                state_n = CAP;
            end
            CAP: state_n = op_q[3] ? WR : IDLE;
            WR: begin
                MEMWRITE   = 1'b1;
                ADDR       = {2'b00, addr_q[31:2]};
                WRITE_DATA = wdata_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Lane extraction for loads and lane merge for SB/SH both work off the captured word.
    always_comb begin
        rd_lane = 16'(READ_DATA >> {addr_q[1:0], 3'b000});
        case (op_q[1:0])
            2'b00:   ld_ext = {{24{rd_lane[7] & ~op_q[2]}}, rd_lane[7:0]};
            2'b01:   ld_ext = {{16{rd_lane[15] & ~op_q[2]}}, rd_lane[15:0]};
            default: ld_ext = READ_DATA;
        endcase
        merged = READ_DATA;
        if (op_q[1:0] == 2'b00)
            merged[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            op_q      <= 4'd0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            LOAD_DATA <= 32'd0;
            DONE      <= 1'b0;
            FAULT     <= 1'b0;
        end else begin
            DONE  <= 1'b0;
            FAULT <= 1'b0;
            if (accept) begin
                if (req_fault) begin
                    DONE  <= 1'b1;
                    FAULT <= 1'b1;
                end else begin
                    op_q    <= OP;
                    addr_q  <= BYTE_ADDR;
                    wdata_q <= STORE_DATA;
                end
            end
            if (state == CAP) begin
                if (op_q[3]) begin
                    wdata_q <= merged;
                end else begin
                    LOAD_DATA <= ld_ext;
                    DONE      <= 1'b1;
                end
            end
            if (state == WR)
                DONE <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: directed scenarios then random traffic against a word-array model.
module tb_mem_access_unit;
    localparam int DEPTH = 32;
    localparam int AW    = 5;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        REQ = 1'b0;
    logic [3:0]  OP = 4'd0;
    logic [31:0] BYTE_ADDR = 32'd0;
    logic [31:0] STORE_DATA = 32'd0;
    logic        READY, DONE, FAULT, MEMREAD, MEMWRITE;
    logic [31:0] LOAD_DATA, ADDR, WRITE_DATA;
    logic [31:0] READ_DATA;

    logic        mem_load = 1'b1;
    logic [31:0] mem     [DEPTH];
    logic [31:0] ref_mem [DEPTH];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_ld = 32'd0;

    typedef struct packed {
        int          acc;
        int          exp;
        logic        fault;
        logic        is_load;
        logic        is_sw;
        logic        is_sub;
        logic [31:0] widx;
        logic [31:0] ld;
        logic [31:0] wd;
    } exp_t;
    exp_t q[$];

    mem_access_unit #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .OP(OP), .BYTE_ADDR(BYTE_ADDR),
        .STORE_DATA(STORE_DATA), .READY(READY), .DONE(DONE), .FAULT(FAULT),
        .LOAD_DATA(LOAD_DATA), .MEMREAD(MEMREAD), .MEMWRITE(MEMWRITE),
        .ADDR(ADDR), .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int i);
        return (32'h9E37_79B9 * 32'(i + 1)) ^ 32'h5A5A_0F0F;
    endfunction

    // Data memory: registered read, garbage on READ_DATA when not reading.
    always @(posedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= pat(i);
        end else if (MEMWRITE && ADDR < 32'(DEPTH)) begin
            mem[ADDR[AW-1:0]] <= WRITE_DATA;
        end
        if (MEMREAD && ADDR < 32'(DEPTH)) READ_DATA <= mem[ADDR[AW-1:0]];
        else                              READ_DATA <= $urandom;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Reference model: byte-granular view of a word array.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit upd, output exp_t e);
        int          size;
        logic [31:0] w, v;
        bit          legal;
        e     = '0;
        legal = op inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
        size  = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
        e.fault   = !legal || (a % size) != 0 || (a >> 2) >= DEPTH;
        e.is_load = legal && !op[3];
        e.is_sw   = (op == 4'hA);
        e.is_sub  = (op == 4'h8) || (op == 4'h9);
        e.widx    = a >> 2;
        if (!e.fault) begin
            w = ref_mem[e.widx[AW-1:0]];
            if (e.is_load) begin
                v = w >> (8 * (a % 4));
                if (size == 1) begin
                    v = v & 32'hFF;
                    if (!op[2] && v >= 128) v = v - 256;
                end else if (size == 2) begin
                    v = v & 32'hFFFF;
                    if (!op[2] && v >= 32768) v = v - 65536;
                end
                e.ld = v;
            end else begin
                for (int i = 0; i < size; i++) w[8 * (a % 4 + i) +: 8] = d[8 * i +: 8];
                e.wd = w;
                if (upd) ref_mem[e.widx[AW-1:0]] = w;
            end
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the accept-edge cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] d,
                         input bit hold, input bit abort, output int acc);
        exp_t e;
        int   lat;
        int   n = 0;
        REQ = 1'b1; OP = op; BYTE_ADDR = a; STORE_DATA = d;
        while (!READY && n < 50) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("accept_ready", 32'(READY), 32'd1);
        acc = -1;
        if (READY) begin
            model(op, a, d, !abort, e);
            lat   = e.fault ? 1 : e.is_sw ? 2 : e.is_load ? 3 : 4;
            acc   = cyc + 1;
            e.acc = acc;
            e.exp = acc + lat - 1;
            q.push_back(e);
            @(posedge CLK); #1;
        end
        if (!hold || acc < 0) REQ = 1'b0;
    endtask

    task automatic monitor();
        logic have, edone, busy, mr, mw;
        forever begin
            @(negedge CLK);
            if (RESET && !mem_load) begin
                have  = q.size() > 0;
                edone = have && q[0].exp == cyc;
                busy  = have && q[0].acc <= cyc && cyc < q[0].exp;
                mr    = have && !q[0].fault && (q[0].is_load || q[0].is_sub) && cyc == q[0].acc;
                mw    = have && !q[0].fault &&
                        ((q[0].is_sw && cyc == q[0].acc) || (q[0].is_sub && cyc == q[0].acc + 2));
                chk("ready", 32'(READY), 32'(!busy));
                chk("done", 32'(DONE), 32'(edone));
                chk("memread", 32'(MEMREAD), 32'(mr));
                chk("memwrite", 32'(MEMWRITE), 32'(mw));
                if (mr || mw) chk("addr", ADDR, q[0].widx);
                if (mw)       chk("write_data", WRITE_DATA, q[0].wd);
                if (!MEMREAD && !MEMWRITE) chk("idle_bus", ADDR | WRITE_DATA, 32'd0);
                if (edone) begin
                    chk("fault", 32'(FAULT), 32'(q[0].fault));
                    if (q[0].is_load && !q[0].fault) last_ld = q[0].ld;
                    chk("load_data", LOAD_DATA, last_ld);
                    void'(q.pop_front());
                end else begin
                    chk("fault_idle", 32'(FAULT), 32'd0);
                end
            end
        end
    endtask

    initial begin
        int          acc1, acc2, acc3, acc;
        int          sel, n;
        logic [3:0]  op;
        logic [31:0] a;
        logic [3:0]  legal_ops [8];
        legal_ops = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = pat(i);

        fork
            monitor();
        join_none

        repeat (3) @(posedge CLK);
        #1;
        chk("reset_ctrl", 32'({READY, DONE, FAULT, MEMREAD, MEMWRITE}), 32'b10000);
        chk("reset_data", LOAD_DATA | ADDR | WRITE_DATA, 32'd0);
        mem_load = 1'b0;
        RESET    = 1'b1;
        @(posedge CLK); #1;

        // Word store/load round trip
        issue(4'hA, 32'h08, 32'hDEADBEEF, 0, 0, acc);
        issue(4'h2, 32'h08, 32'd0, 0, 0, acc);
        // Sub-word loads of 0xDEADBEEF
        issue(4'h0, 32'h0B, 32'd0, 0, 0, acc);
        issue(4'h4, 32'h0B, 32'd0, 0, 0, acc);
        issue(4'h1, 32'h0A, 32'd0, 0, 0, acc);
        issue(4'h5, 32'h0A, 32'd0, 0, 0, acc);
        issue(4'h0, 32'h08, 32'd0, 0, 0, acc);
        // Read-modify-write stores
        issue(4'h8, 32'h09, 32'h00000055, 0, 0, acc);
        issue(4'h9, 32'h0A, 32'h00001234, 0, 0, acc);
        issue(4'h2, 32'h08, 32'd0, 0, 0, acc);
        // Faulting requests
        issue(4'h2, 32'h06, 32'd0, 0, 0, acc);
        issue(4'h1, 32'h03, 32'd0, 0, 0, acc);
        issue(4'hA, 32'h80, 32'h11111111, 0, 0, acc);
        issue(4'h7, 32'h00, 32'd0, 0, 0, acc);
        issue(4'hA, 32'h7C, 32'hCAFEF00D, 0, 0, acc);

        // Reset in the capture cycle of an SH must suppress its write
        issue(4'h9, 32'h0C, 32'h00005678, 0, 1, acc);
        @(posedge CLK); #1;
        RESET = 1'b0;
        q.delete();
        #1;
        chk("midreset_ctrl", 32'({READY, DONE, FAULT, MEMREAD, MEMWRITE}), 32'b10000);
        chk("midreset_data", LOAD_DATA | ADDR | WRITE_DATA, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET   = 1'b1;
        last_ld = 32'd0;
        issue(4'h2, 32'h0C, 32'd0, 0, 0, acc);

        // REQ held high: each request is taken in the previous DONE cycle
        issue(4'h2, 32'h08, 32'd0, 1, 0, acc1);
        issue(4'hA, 32'h10, 32'hA5A5_1234, 1, 0, acc2);
        issue(4'h0, 32'h09, 32'd0, 0, 0, acc3);
        chk("b2b_after_load", 32'(acc2), 32'(acc1 + 3));
        chk("b2b_after_store", 32'(acc3), 32'(acc2 + 2));

        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 99);
            op  = (sel < 8) ? 4'($urandom_range(0, 15)) : legal_ops[$urandom_range(0, 7)];
            sel = $urandom_range(0, 99);
            if (sel < 5)       a = $urandom;
            else if (sel < 12) a = 32'($urandom_range(120, 135));
            else               a = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 99) < 70) begin
                if (op[1:0] == 2'd2) a[1:0] = 2'b00;
                if (op[1:0] == 2'd1) a[0]   = 1'b0;
            end
            sel = $urandom_range(0, 1);
            issue(op, a, $urandom, sel[0], 0, acc);
            if (sel == 0) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge CLK); #1;
                end
            end
        end
        REQ = 1'b0;

        n = 0;
        while (q.size() > 0 && n < 100) begin
            @(posedge CLK); #1;
            n++;
        end
        chk("drain", 32'(q.size()), 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        for (int i = 0; i < DEPTH; i++) chk("mem_word", mem[i], ref_mem[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Load/store initiator on the data-memory port. It accepts one load or store request from the execute stage and converts the byte address to the memory's word index. It sequences MEMREAD/MEMWRITE cycles against the word-wide data memory, whose read data is registered one cycle after MEMREAD. Sub-word stores are done as read-modify-write. Sub-word loads are lane-extracted and sign- or zero-extended before they are returned to the pipeline.

Parameters:
DEPTH, 32, number of 32-bit words in the data memory; word indices at or above DEPTH fault.

Ports:
CLK  in  1  clock; all state changes on rising edge
RESET  in  1  asynchronous, active-low reset
REQ  in  1  request valid from pipeline
OP  in  4  0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW; any other code is illegal
BYTE_ADDR  in  32  byte address
STORE_DATA  in  32  store data; SB uses [7:0], SH uses [15:0]
READY  out  1  unit idle, request may be accepted
DONE  out  1  one-cycle completion pulse
FAULT  out  1  qualifies DONE: request rejected, no memory access made
LOAD_DATA  out  32  extended load result, held until next load completes
MEMREAD  out  1  to data memory
MEMWRITE  out  1  to data memory
ADDR  out  32  word index to data memory = BYTE_ADDR >> 2
WRITE_DATA  out  32  word to data memory
READ_DATA  in  32  from data memory, valid the cycle after a MEMREAD cycle

Behaviour:
- States: IDLE, RD, CAP, WR.
- READY = (state == IDLE).
- Request handshake:
  - Request is accepted on a rising edge with REQ & READY.
  - OP, BYTE_ADDR and STORE_DATA are latched on acceptance; inputs are ignored at all other times.
- Fault check at acceptance. The request faults if any of these hold:
  - OP is illegal;
  - half-word op with BYTE_ADDR[0] = 1;
  - word op with BYTE_ADDR[1:0] != 0;
  - BYTE_ADDR[31:2] >= DEPTH.
- On a fault: DONE = 1 and FAULT = 1 in the next cycle, state stays IDLE, MEMREAD and MEMWRITE are never asserted.
- Transitions from IDLE on a good request:
  - loads, SB, SH -> RD;
  - SW -> WR with WRITE_DATA = STORE_DATA.
- RD: MEMREAD = 1 and ADDR = word index for exactly one cycle, then -> CAP.
- CAP: READ_DATA is sampled only in this state. Next:
  - Load: LOAD_DATA is updated from READ_DATA; DONE pulses next cycle; -> IDLE.
  - SB: WRITE_DATA = READ_DATA with lane BYTE_ADDR[1:0] replaced by STORE_DATA[7:0]; -> WR.
  - SH: WRITE_DATA = READ_DATA with half BYTE_ADDR[1] replaced by STORE_DATA[15:0]; -> WR.
- WR: MEMWRITE = 1 and ADDR = word index for exactly one cycle; DONE pulses next cycle; -> IDLE.
- Lane order is little-endian: byte 0 = [7:0], half 0 = [15:0].
- Extension: LB/LH sign-extend, LBU/LHU zero-extend, LW passes through unchanged.
- Latency from the accept edge to the DONE-high cycle:
  - fault: 1 cycle;
  - SW: 2 cycles;
  - loads: 3 cycles;
  - SB/SH: 4 cycles.
- Back-to-back: the state is IDLE during the DONE cycle, so a new request can be accepted there. DONE and FAULT are deasserted in every other cycle.
- MEMREAD and MEMWRITE are never high together, and each is high for at most one consecutive cycle per request.
- ADDR and WRITE_DATA are 0 whenever MEMREAD and MEMWRITE are both low.
- Reset (RESET = 0, any time including mid-operation):
  - state -> IDLE immediately;
  - MEMREAD = MEMWRITE = DONE = FAULT = 0;
  - LOAD_DATA = ADDR = WRITE_DATA = 0;
  - a partially executed SB/SH never writes.
  - READY = 1 while reset is held and after release.

Test Plan:
1. SW 0xDEADBEEF @0x08 -> one MEMWRITE cycle with ADDR = 2 and WRITE_DATA = 0xDEADBEEF, DONE 2 cycles after accept. Then LW @0x08 -> one MEMREAD cycle, LOAD_DATA = 0xDEADBEEF, DONE 3 cycles after accept.
2. With word 2 = 0xDEADBEEF:
   - LB @0x0B -> 0xFFFFFFDE; LBU @0x0B -> 0x000000DE.
   - LH @0x0A -> 0xFFFFDEAD; LHU @0x0A -> 0x0000DEAD.
   - LB @0x08 -> 0xFFFFFFEF.
3. SB 0x55 @0x09 -> MEMREAD then MEMWRITE with WRITE_DATA = 0xDEAD55EF. Then SH 0x1234 @0x0A -> 0x123455EF; LW @0x08 confirms 0x123455EF.
4. Faults: LW @0x06, LH @0x03, SW @0x80 (word 32 >= DEPTH), OP = 0111 -> each gives DONE = FAULT = 1 one cycle after accept, no MEMREAD/MEMWRITE, memory unchanged.
5. Assert RESET low while in CAP of SH @0x0C -> MEMWRITE never asserted, all outputs 0, READY = 1. After release, LW @0x0C returns the prior contents.
6. Hold REQ high across LW, SW, LB -> READY low during each operation, each next request accepted in the previous DONE cycle, no request dropped or duplicated (three DONE pulses).
